// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude/equality comparator: compares WIDTH-bit operands CHUNK bits per cycle, MSB chunk first.
// Optional macro COMP_EARLY_EXIT_EN: finish as soon as the first differing chunk is found.
module seq_mag_comparator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             res,
    output logic             eq,
    output logic             lt,
    output logic             gt,
    output logic [1:0]       dbg_state
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             started_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       mode_q;
    logic             signed_q;
    logic [IDXW-1:0]  idx_q;
    logic             decided_q, lt_q, gt_q;
    logic             res_q, eq_out_q, lt_out_q, gt_out_q;

    logic             accept;
    logic             run_exit;
    logic             chunk_diff;
    logic             decided_d, lt_d, gt_d, res_d;
    logic [CHUNK-1:0] ca, cb;

    // Operands shift left each RUN cycle, so the chunk under test is always the top CHUNK bits.
    always_comb begin
        ca = a_q[WIDTH-1 -: CHUNK];
        cb = b_q[WIDTH-1 -: CHUNK];
        if (signed_q && (idx_q == IDX_TOP)) begin
            ca[CHUNK-1] = ~ca[CHUNK-1];
            cb[CHUNK-1] = ~cb[CHUNK-1];
        end
        chunk_diff = (ca != cb);
        decided_d  = decided_q;
        lt_d       = lt_q;
        gt_d       = gt_q;
        if (!decided_q && chunk_diff) begin
            decided_d = 1'b1;
            lt_d      = (ca < cb);
            gt_d      = (ca > cb);
        end
        run_exit = (idx_q == '0);
`ifdef COMP_EARLY_EXIT_EN
        if (!decided_q && chunk_diff) begin
            run_exit = 1'b1;
        end
`endif
        case (mode_q)
            3'd0:    res_d = !decided_d;
            3'd1:    res_d = decided_d;
            3'd2:    res_d = lt_d;
            3'd3:    res_d = lt_d | !decided_d;
            3'd4:    res_d = gt_d;
            3'd5:    res_d = gt_d | !decided_d;
            default: res_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (run_exit) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) && started_q;
        out_valid = (state_q == S_DONE);
        accept    = in_ready && in_valid;
        dbg_state = state_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= '0;
            signed_q  <= 1'b0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
            gt_q      <= 1'b0;
            res_q     <= 1'b0;
            eq_out_q  <= 1'b0;
            lt_out_q  <= 1'b0;
            gt_out_q  <= 1'b0;
        end else begin
            started_q <= 1'b1;
            if (accept) begin
                a_q       <= a;
                b_q       <= b;
                mode_q    <= mode;
                signed_q  <= is_signed;
                idx_q     <= IDX_TOP;
                decided_q <= 1'b0;
                lt_q      <= 1'b0;
                gt_q      <= 1'b0;
            end else if (state_q == S_RUN) begin
                a_q       <= a_q << CHUNK;
                b_q       <= b_q << CHUNK;
                decided_q <= decided_d;
                lt_q      <= lt_d;
                gt_q      <= gt_d;
                if (run_exit) begin
                    res_q    <= res_d;
                    eq_out_q <= !decided_d;
                    lt_out_q <= lt_d;
                    gt_out_q <= gt_d;
                end else begin
                    idx_q <= idx_q - 1'b1;
                end
            end
        end
    end

    assign res = res_q;
    assign eq  = eq_out_q;
    assign lt  = lt_out_q;
    assign gt  = gt_out_q;

endmodule
